cam_frame_tx: RTL and testbench

//  Synthesizable camera-side transmitter: drives CAM_VSYNC/CAM_HREF/CAM_px_data like an OV7670 in RGB565,
//  two bytes per pixel, high byte first. Feeds the capture path in loopback on the board and in benches

---
 rtl/cam_frame_tx.sv | 237 +++++++++++++++++++++++
 tb/tb_cam_frame_tx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cam_frame_tx.sv
// OV7670-style RGB565 transmitter: VSYNC/HREF framing with internally generated test patterns.
// Optional FRAME_STAMP_EN: pixel (0,0) of each frame becomes {8'hA5, frame_cnt}.
module cam_frame_tx #(
    parameter int H_ACTIVE   = 160,
    parameter int V_ACTIVE   = 120,
    parameter int H_BLANK    = 16,
    parameter int VS_CYCLES  = 32,
    parameter int VBP_CYCLES = 10,
    parameter int VFP_CYCLES = 10
) (
    input  logic        CAM_PCLK,
    input  logic        rst,
    input  logic        enable,
    input  logic        single_shot,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_color,
    output logic        CAM_VSYNC,
    output logic        CAM_HREF,
    output logic [7:0]  CAM_px_data,
    output logic        frame_done,
    output logic [7:0]  frame_cnt
);

    localparam int X_W     = $clog2(H_ACTIVE);
    localparam int Y_W     = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int BAR_LEN = H_ACTIVE / 8;
    localparam int BAR_W   = (BAR_LEN > 1) ? $clog2(BAR_LEN) : 1;
    localparam int MAX_A   = (VS_CYCLES > VBP_CYCLES) ? VS_CYCLES : VBP_CYCLES;
    localparam int MAX_B   = (H_BLANK > VFP_CYCLES) ? H_BLANK : VFP_CYCLES;
    localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(MAX_C + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_VSYNC, S_VBP, S_LINE, S_HBLANK, S_VFP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic               byte_q, byte_d;
    logic [2:0]         bar_idx_q, bar_idx_d;
    logic [BAR_W-1:0]   bar_px_q, bar_px_d;
    logic [1:0]         sel_q, sel_d;
    logic [15:0]        solid_q, solid_d;
    logic               ss_q, ss_d;
    logic               shot_done_q, shot_done_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;
    logic               vsync_q, href_q, done_q;
    logic [7:0]         px_q;
    logic               start;
    logic [15:0]        pix_d;
    logic [4:0]         gx;
    logic [5:0]         gy;
    logic [7:0]         px_d;
    logic               done_d;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return 16'hFFFF;
            3'd1:    return 16'hFFE0;
            3'd2:    return 16'h07FF;
            3'd3:    return 16'h07E0;
            3'd4:    return 16'hF81F;
            3'd5:    return 16'hF800;
            3'd6:    return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        byte_d      = byte_q;
        bar_idx_d   = bar_idx_q;
        bar_px_d    = bar_px_q;
        sel_d       = sel_q;
        solid_d     = solid_q;
        ss_d        = ss_q;
        shot_done_d = shot_done_q;
        frame_cnt_d = frame_cnt_q;
        start       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // After a single-shot frame, enable must drop before another frame can start
                if (!enable) begin
                    shot_done_d = 1'b0;
                end else if (!shot_done_q) begin
                    start = 1'b1;
                end
            end
            S_VSYNC: begin
                if (cnt_q == CNT_W'(VS_CYCLES - 1)) begin
                    state_d = S_VBP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_VBP: begin
                if (cnt_q == CNT_W'(VBP_CYCLES - 1)) begin
                    state_d = S_LINE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LINE: begin
                byte_d = ~byte_q;
                if (byte_q) begin
                    if (x_q == X_W'(H_ACTIVE - 1)) begin
                        x_d       = '0;
                        bar_idx_d = '0;
                        bar_px_d  = '0;
                        cnt_d     = '0;
                        if (y_q == Y_W'(V_ACTIVE - 1)) begin
                            state_d = S_VFP;
                        end else begin
                            state_d = S_HBLANK;
                            y_d     = y_q + 1'b1;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                        if (bar_px_q == BAR_W'(BAR_LEN - 1)) begin
                            bar_px_d  = '0;
                            bar_idx_d = bar_idx_q + 1'b1;
                        end else begin
                            bar_px_d = bar_px_q + 1'b1;
                        end
                    end
                end
            end
            S_HBLANK: begin
                if (cnt_q == CNT_W'(H_BLANK - 1)) begin
                    state_d = S_LINE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_VFP: begin
                if (cnt_q == CNT_W'(VFP_CYCLES - 1)) begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                    if (enable && !ss_q) begin
                        start = 1'b1;
                    end else begin
                        state_d     = S_IDLE;
                        shot_done_d = enable;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (start) begin
            state_d   = S_VSYNC;
            cnt_d     = '0;
            x_d       = '0;
            y_d       = '0;
            byte_d    = 1'b0;
            bar_idx_d = '0;
            bar_px_d  = '0;
            sel_d     = pattern_sel;
            solid_d   = solid_color;
            ss_d      = single_shot;
        end
    end

    // Pixel is evaluated on next-state coordinates so every output leaves a flop
    always_comb begin
        gx = 5'(x_d);
        gy = 6'(y_d);
        case (sel_q)
            2'd0:    pix_d = bar_color(bar_idx_d);
            2'd1:    pix_d = {gx, gy, gx};
            2'd2:    pix_d = (gx[3] ^ gy[3]) ? 16'hFFFF : 16'h0000;
            default: pix_d = solid_q;
        endcase
`ifdef FRAME_STAMP_EN
        if (x_d == '0 && y_d == '0) begin
            pix_d = {8'hA5, frame_cnt_q};
        end
`endif
        px_d   = (state_d == S_LINE) ? (byte_d ? pix_d[7:0] : pix_d[15:8]) : 8'h00;
        done_d = (state_d == S_VFP) && (cnt_d == CNT_W'(VFP_CYCLES - 1));
    end

    always_ff @(posedge CAM_PCLK) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            byte_q      <= 1'b0;
            bar_idx_q   <= '0;
            bar_px_q    <= '0;
            sel_q       <= '0;
            solid_q     <= '0;
            ss_q        <= 1'b0;
            shot_done_q <= 1'b0;
            frame_cnt_q <= '0;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            px_q        <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            byte_q      <= byte_d;
            bar_idx_q   <= bar_idx_d;
            bar_px_q    <= bar_px_d;
            sel_q       <= sel_d;
            solid_q     <= solid_d;
            ss_q        <= ss_d;
            shot_done_q <= shot_done_d;
            frame_cnt_q <= frame_cnt_d;
            vsync_q     <= (state_d == S_VSYNC);
            href_q      <= (state_d == S_LINE);
            px_q        <= px_d;
            done_q      <= done_d;
        end
    end

    assign CAM_VSYNC   = vsync_q;
    assign CAM_HREF    = href_q;
    assign CAM_px_data = px_q;
    assign frame_done  = done_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_cam_frame_tx.sv
// Directed bench for cam_frame_tx with a small timing/pattern model; each cycle's outputs are compared.
module tb_cam_frame_tx;

    localparam int HA  = 16;
    localparam int VA  = 4;
    localparam int HB  = 5;
    localparam int VS  = 4;
    localparam int VBP = 3;
    localparam int VFP = 3;
    localparam int PERIOD = VS + VBP + 2*HA*VA + (VA-1)*HB + VFP;
`ifdef FRAME_STAMP_EN
    localparam bit STAMP = 1'b1;
`else
    localparam bit STAMP = 1'b0;
`endif

    logic        CAM_PCLK = 1'b0;
    logic        rst;
    logic        enable;
    logic        single_shot;
    logic [1:0]  pattern_sel;
    logic [15:0] solid_color;
    logic        CAM_VSYNC;
    logic        CAM_HREF;
    logic [7:0]  CAM_px_data;
    logic        frame_done;
    logic [7:0]  frame_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_vs = 0;

    always #5 CAM_PCLK = ~CAM_PCLK;
    always @(posedge CAM_PCLK) cyc <= cyc + 1;

    cam_frame_tx #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
        .VS_CYCLES(VS), .VBP_CYCLES(VBP), .VFP_CYCLES(VFP)
    ) dut (
        .CAM_PCLK(CAM_PCLK), .rst(rst), .enable(enable), .single_shot(single_shot),
        .pattern_sel(pattern_sel), .solid_color(solid_color),
        .CAM_VSYNC(CAM_VSYNC), .CAM_HREF(CAM_HREF), .CAM_px_data(CAM_px_data),
        .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CAM_PCLK);
        #1;
    endtask

    function automatic logic [31:0] pack(input logic vs, input logic hr, input logic dn,
                                         input logic [7:0] cnt, input logic [7:0] px);
        return {13'd0, vs, hr, dn, cnt, px};
    endfunction

    function automatic logic [31:0] obs_pack();
        return pack(CAM_VSYNC, CAM_HREF, frame_done, frame_cnt, CAM_px_data);
    endfunction

    function automatic logic [15:0] exp_pix(input int sel, input int x, input int y,
                                            input logic [15:0] solid, input logic [7:0] cnt);
        logic [15:0] p;
        logic [4:0]  gx;
        logic [5:0]  gy;
        gx = x[4:0];
        gy = y[5:0];
        case (sel)
            0: case (x / (HA/8))
                   0: p = 16'hFFFF;
                   1: p = 16'hFFE0;
                   2: p = 16'h07FF;
                   3: p = 16'h07E0;
                   4: p = 16'hF81F;
                   5: p = 16'hF800;
                   6: p = 16'h001F;
                   default: p = 16'h0000;
               endcase
            1: p = {gx, gy, gx};
            2: p = (gx[3] ^ gy[3]) ? 16'hFFFF : 16'h0000;
            default: p = solid;
        endcase
        if (STAMP && x == 0 && y == 0) p = {8'hA5, cnt};
        return p;
    endfunction

    task automatic exp_idle(input logic [7:0] cnt, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk("idle", obs_pack(), pack(1'b0, 1'b0, 1'b0, cnt, 8'h00));
        end
    endtask

    task automatic exp_vsync(input logic [7:0] cnt, input bit per);
        for (int i = 0; i < VS; i++) begin
            step();
            if (i == 0) begin
                if (per) chk("vsync_period", cyc - last_vs, PERIOD);
                last_vs = cyc;
            end
            chk("vsync", obs_pack(), pack(1'b1, 1'b0, 1'b0, cnt, 8'h00));
        end
    endtask

    // Inputs are scrambled once the frame has started: the frame must keep its latched settings
    task automatic exp_vbp(input logic [7:0] cnt);
        for (int i = 0; i < VBP; i++) begin
            step();
            if (i == 0) begin
                pattern_sel = ~pattern_sel;
                solid_color = ~solid_color;
                single_shot = ~single_shot;
            end
            chk("vbp", obs_pack(), pack(1'b0, 1'b0, 1'b0, cnt, 8'h00));
        end
    endtask

    task automatic exp_line(input int sel, input logic [15:0] solid, input int y,
                            input logic [7:0] cnt, input int nbytes, input int drop_at);
        logic [15:0] p;
        logic [7:0]  b8;
        for (int b = 0; b < nbytes; b++) begin
            step();
            if (b == drop_at) enable = 1'b0;
            p  = exp_pix(sel, b / 2, y, solid, cnt);
            b8 = (b % 2 == 1) ? p[7:0] : p[15:8];
            chk($sformatf("line%0d_byte%0d", y, b), obs_pack(), pack(1'b0, 1'b1, 1'b0, cnt, b8));
        end
    endtask

    task automatic exp_hblank(input logic [7:0] cnt);
        for (int i = 0; i < HB; i++) begin
            step();
            chk("hblank", obs_pack(), pack(1'b0, 1'b0, 1'b0, cnt, 8'h00));
        end
    endtask

    task automatic exp_vfp(input logic [7:0] cnt);
        for (int i = 0; i < VFP; i++) begin
            step();
            chk("vfp", obs_pack(), pack(1'b0, 1'b0, (i == VFP-1), cnt, 8'h00));
        end
    endtask

    task automatic exp_frame(input int sel, input logic [15:0] solid, input logic ss,
                             input logic [7:0] cnt, input bit per);
        pattern_sel = sel[1:0];
        solid_color = solid;
        single_shot = ss;
        exp_vsync(cnt, per);
        exp_vbp(cnt);
        for (int y = 0; y < VA; y++) begin
            exp_line(sel, solid, y, cnt, 2*HA, -1);
            if (y < VA-1) exp_hblank(cnt);
        end
        exp_vfp(cnt);
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        single_shot = 1'b0;
        pattern_sel = 2'd0;
        solid_color = 16'h0000;
        exp_idle(8'd0, 2);

        // Colour bars from reset, then continuous gradient and checker frames
        rst = 1'b0;
        enable = 1'b1;
        exp_frame(0, 16'h0000, 1'b0, 8'd0, 1'b0);
        exp_frame(1, 16'h0000, 1'b0, 8'd1, 1'b1);
        exp_frame(2, 16'h0000, 1'b0, 8'd2, 1'b1);
        enable = 1'b0;
        exp_idle(8'd3, 5);

        // Single shot: stays idle while enable remains high
        enable = 1'b1;
        exp_frame(3, 16'h1234, 1'b1, 8'd3, 1'b0);
        exp_idle(8'd4, 10);
        enable = 1'b0;
        exp_idle(8'd4, 2);

        // Enable dropped during line 1: frame still completes
        enable = 1'b1;
        pattern_sel = 2'd1;
        solid_color = 16'h0000;
        single_shot = 1'b0;
        exp_vsync(8'd4, 1'b0);
        exp_vbp(8'd4);
        exp_line(1, 16'h0000, 0, 8'd4, 2*HA, -1);
        exp_hblank(8'd4);
        exp_line(1, 16'h0000, 1, 8'd4, 2*HA, 10);
        exp_hblank(8'd4);
        exp_line(1, 16'h0000, 2, 8'd4, 2*HA, -1);
        exp_hblank(8'd4);
        exp_line(1, 16'h0000, 3, 8'd4, 2*HA, -1);
        exp_vfp(8'd4);
        exp_idle(8'd5, 8);

        // Reset in the middle of a line, then restart
        enable = 1'b1;
        pattern_sel = 2'd0;
        single_shot = 1'b0;
        exp_vsync(8'd5, 1'b0);
        exp_vbp(8'd5);
        exp_line(0, 16'h0000, 0, 8'd5, 11, -1);
        rst = 1'b1;
        exp_idle(8'd0, 2);
        rst = 1'b0;
        exp_frame(0, 16'h0000, 1'b0, 8'd0, 1'b0);

        // Solid colour frames; third frame since reset carries stamp 02 when enabled
        exp_frame(3, 16'h1234, 1'b0, 8'd1, 1'b1);
        exp_frame(3, 16'h1234, 1'b0, 8'd2, 1'b1);
        enable = 1'b0;
        exp_idle(8'd3, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
